komut_sequencer: RTL and testbench
==================================

// Module: komut_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the instruction decoder and the 32x32 register file.
//  Fetches instruction words (komut) from instruction memory, drives the decoder, and latches the decoder outputs and register operands.
//  Executes R/I/U/B operations and writes results back to the register file.
//  Sits between the instruction memory and the decoder/regfile pair, one instruction at a time.
// PARAMETERS
//  ADDR_W    6             instruction memory word-address width (IMEM depth = 2**ADDR_W words)
//  START_PC  32'h0000_0000 byte PC loaded on reset and on restart from HALT
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   begin execution; sampled only in IDLE or HALT
//  imem_addr  out  ADDR_W  word address to IMEM = pc[ADDR_W+1:2]
//  imem_data  in   32  IMEM read data, combinational w.r.t. imem_addr
//  komut      out  32  latched instruction word, drives decoder input
//  opcode     in   7   decoder output
//  aluop      in   4   decoder output
//  rs1/rs2    in   5   decoder outputs; also drive regfile read addresses externally
//  rd         in   5   decoder output
//  imm        in   32  decoder output
//  hata       in   1   decoder illegal-opcode flag
//  rs1_data/rs2_data in 32  regfile read data (combinational)
//  wr_en      out  1   regfile write strobe, one cycle
//  wr_addr    out  5   regfile write address
//  wr_data    out  32  regfile write data
//  pc         out  32  current byte PC
//  busy       out  1   high in FETCH/DECODE/EXEC/WB
//  halted     out  1   high in HALT
//  err        out  1   high in ERR (sticky until rst)
//  retired    out  16  instructions completed, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset values: state=IDLE, pc=START_PC, komut=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, halted=0, err=0, retired=0.
//  FSM and latency:
//   IDLE -start-> FETCH.
//   FETCH: komut<=imem_data; ->DECODE.
//   DECODE: if komut==32'h0 ->HALT; else if hata ->ERR; else latch op/aluop/rd/imm and A=rs1_data, B=(R?rs2_data:imm); B-type latches both register operands; ->EXEC.
//   EXEC: compute res; ->WB.
//   WB: write/branch, retired++, ->FETCH.
//   HALT -start-> FETCH with pc=START_PC, retired kept.
//   ERR: terminal; only rst leaves.
//   Each instruction takes exactly 4 cycles, FETCH to WB.
//  Opcodes: R=7'b0000001, I=7'b0000011, U=7'b0000111, B=7'b0001111.
//  ALU (R uses all 4 aluop bits; I forces bit3=0):
//   0000 add, 1000 sub, 0001 sll B[4:0], 0100 xor, 0101 srl B[4:0], 1101 sra B[4:0], 0110 or, 0111 and.
//   Any other aluop gives res=0, no error.
//   All arithmetic mod 2^32; no overflow flag.
//  U-type: res = imm<<12 (imm already zero-extended 20-bit field).
//  B-type compare:
//   aluop[2:0]=000 taken if A==B; 001 taken if A!=B.
//   100 taken if signed A<B; 101 taken if signed A>=B.
//   Other encodings never taken.
//  WB stage:
//   R/I/U: wr_en=1 for exactly that cycle, wr_addr=rd, wr_data=res.
//   Writes to rd==0 suppressed (wr_en=0); x0 stays architecturally zero.
//   B: no write.
//   pc <= taken ? pc+imm : pc+4, mod 2^32; IMEM index wraps naturally via pc[ADDR_W+1:2].
//  start while busy/ERR is ignored.
//  Async rst mid-instruction aborts immediately; no partial write is issued after rst deasserts.
//  In HALT and ERR, pc holds the address of the halting/faulting instruction.
// TESTING
//  1 reset, then start with IMEM[0]=R add x3=x1+x2 (x1=5,x2=7), IMEM[1]=0
//    -> wr_en cycle 4 after FETCH with wr_addr=3, wr_data=12; halted at pc=4; retired=1.
//  2 I-type xor imm=12'h0FF on x1=32'h0000_0F0F, rd=4 -> wr_data=32'h0000_0FF0; then R sub x5=x1-x2 with x1=0,x2=1 -> 32'hFFFF_FFFF.
//  3 B-type beq x1==x1 imm=8 at pc=0 -> next fetch pc=8, no wr_en.
//    bne equal operands -> pc=4.
//  4 illegal opcode 7'b1111111 at pc=8 -> err=1, busy=0, pc=8; start and further cycles leave state unchanged until rst.
//  5 R-type with rd=0 -> wr_en stays 0 all 4 cycles; U-type imm=20'hABCDE, rd=6 -> wr_data=32'hABCDE000.
//  6 assert rst in EXEC of an R instruction -> all outputs return to reset values same cycle; no wr_en after release; restart executes from START_PC.

Source files
------------

// File: rtl/komut_sequencer_if.sv
// Sequencer <-> IMEM / decoder / register-file bundle.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface komut_sequencer_if #(parameter int ADDR_W = 6);
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       komut;
    logic [6:0]        opcode;
    logic [3:0]        aluop;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic              hata;
    logic [31:0]       rs1_data;
    logic [31:0]       rs2_data;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic [31:0]       pc;
    logic              busy;
    logic              halted;
    logic              err;
    logic [15:0]       retired;

    modport master (
        input  start, imem_data, opcode, aluop, rs1, rs2, rd, imm, hata, rs1_data, rs2_data,
        output imem_addr, komut, wr_en, wr_addr, wr_data, pc, busy, halted, err, retired
    );
    modport slave (
        output start, imem_data, opcode, aluop, rs1, rs2, rd, imm, hata, rs1_data, rs2_data,
        input  imem_addr, komut, wr_en, wr_addr, wr_data, pc, busy, halted, err, retired
    );
endinterface

// File: rtl/komut_sequencer.sv
// Four-cycle FETCH/DECODE/EXEC/WB controller for the decoder + 32x32 regfile pair.
// Executes R/I/U/B instructions one at a time and writes results back.
module komut_sequencer #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] START_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    komut_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [6:0] OP_R = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0000011;
    localparam logic [6:0] OP_U = 7'b0000111;
    localparam logic [6:0] OP_B = 7'b0001111;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] komut;
    logic [6:0]  op_q;
    logic [3:0]  alu_q;
    logic [4:0]  rd_q;
    logic [31:0] imm_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        taken_q;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] retired;

    logic [31:0] res;
    logic        taken;
    logic        writes;

    always_comb begin
        res = '0;
        case (alu_q)
            4'b0000: res = a_q + b_q;
            4'b1000: res = a_q - b_q;
            4'b0001: res = a_q << b_q[4:0];
            4'b0100: res = a_q ^ b_q;
            4'b0101: res = a_q >> b_q[4:0];
            4'b1101: res = $signed(a_q) >>> b_q[4:0];
            4'b0110: res = a_q | b_q;
            4'b0111: res = a_q & b_q;
            default: res = '0;
        endcase
        if (op_q == OP_U)
            res = imm_q << 12;

        taken = 1'b0;
        if (op_q == OP_B) begin
            case (alu_q[2:0])
                3'b000:  taken = (a_q == b_q);
                3'b001:  taken = (a_q != b_q);
                3'b100:  taken = ($signed(a_q) <  $signed(b_q));
                3'b101:  taken = ($signed(a_q) >= $signed(b_q));
                default: taken = 1'b0;
            endcase
        end

        writes = (op_q == OP_R) || (op_q == OP_I) || (op_q == OP_U);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= START_PC;
            komut   <= '0;
            op_q    <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            taken_q <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            retired <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) state <= S_FETCH;
                S_FETCH: begin
                    komut <= bus.imem_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (komut == 32'h0) begin
                        state <= S_HALT;
                    end else if (bus.hata) begin
                        state <= S_ERR;
                    end else begin
                        op_q  <= bus.opcode;
                        // I-type shares funct3 with R but never selects sub/sra
                        alu_q <= (bus.opcode == OP_I) ? {1'b0, bus.aluop[2:0]} : bus.aluop;
                        rd_q  <= bus.rd;
                        imm_q <= bus.imm;
                        a_q   <= bus.rs1_data;
                        b_q   <= (bus.opcode == OP_R || bus.opcode == OP_B) ? bus.rs2_data : bus.imm;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wr_en   <= writes && (rd_q != 5'd0);
                    if (writes) begin
                        wr_addr <= rd_q;
                        wr_data <= res;
                    end
                    taken_q <= taken;
                    state   <= S_WB;
                end
                S_WB: begin
                    pc      <= taken_q ? pc + imm_q : pc + 32'd4;
                    retired <= retired + 16'd1;
                    state   <= S_FETCH;
                end
                S_HALT: begin
                    if (bus.start) begin
                        pc    <= START_PC;
                        state <= S_FETCH;
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_addr = pc[ADDR_W+1:2];
    assign bus.komut     = komut;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.pc        = pc;
    assign bus.busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
    assign bus.halted    = (state == S_HALT);
    assign bus.err       = (state == S_ERR);
    assign bus.retired   = retired;
endmodule

// File: tb/tb_komut_sequencer.sv
// Directed bench for komut_sequencer: behavioural IMEM, decoder and regfile around the DUT,
// expected register writes queued as stimulus is set up and checked as the DUT writes.
module tb_komut_sequencer;
    localparam logic [6:0] OP_R = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0000011;
    localparam logic [6:0] OP_U = 7'b0000111;
    localparam logic [6:0] OP_B = 7'b0001111;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst;
    komut_sequencer_if #(.ADDR_W(6)) bus ();

    komut_sequencer #(.ADDR_W(6), .START_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    bit [31:0] imem [64];
    bit [31:0] regs [32];
    logic       pl_we;
    logic [4:0] pl_a;
    logic [31:0] pl_d;
    wr_t sb [$];
    int cmp;
    int errs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // decoder model: RISC-V-like field layout
    always_comb begin
        bus.opcode = bus.komut[6:0];
        bus.rd     = bus.komut[11:7];
        bus.rs1    = bus.komut[19:15];
        bus.rs2    = bus.komut[24:20];
        bus.aluop  = {bus.komut[30], bus.komut[14:12]};
        case (bus.komut[6:0])
            OP_U:    bus.imm = {12'b0, bus.komut[31:12]};
            OP_B:    bus.imm = {{20{bus.komut[31]}}, bus.komut[31:25], bus.komut[11:7]};
            default: bus.imm = {20'b0, bus.komut[31:20]};
        endcase
        bus.hata = !(bus.komut[6:0] inside {OP_R, OP_I, OP_U, OP_B});
    end

    assign bus.imem_data = imem[bus.imem_addr];
    assign bus.rs1_data  = regs[bus.rs1];
    assign bus.rs2_data  = regs[bus.rs2];

    always @(posedge clk) begin
        if (bus.wr_en && bus.wr_addr != 5'd0)
            regs[bus.wr_addr] <= bus.wr_data;
        else if (pl_we && pl_a != 5'd0)
            regs[pl_a] <= pl_d;
    end

    function automatic logic [31:0] r_ins(input logic [3:0] a, input logic [4:0] rd, rs1, rs2);
        return {1'b0, a[3], 5'b0, rs2, rs1, a[2:0], rd, OP_R};
    endfunction
    function automatic logic [31:0] i_ins(input logic [2:0] f3, input logic [4:0] rd, rs1, input logic [11:0] im);
        return {im, rs1, f3, rd, OP_I};
    endfunction
    function automatic logic [31:0] u_ins(input logic [4:0] rd, input logic [19:0] im);
        return {im, rd, OP_U};
    endfunction
    function automatic logic [31:0] b_ins(input logic [2:0] f3, input logic [4:0] rs1, rs2, input logic [11:0] im);
        return {im[11:5], rs2, rs1, f3, im[4:0], OP_B};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            cmp++;
            assert (sb.size() > 0) else begin
                errs++;
                $error("FAIL unexpected_write: observed addr %0d data %h expected no write", bus.wr_addr, bus.wr_data);
            end
            if (sb.size() > 0) begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", {27'b0, bus.wr_addr}, {27'b0, e.a});
                chk("wr_data", bus.wr_data, e.d);
            end
        end
    end

    task automatic clr_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    // returns at the negedge inside the first FETCH cycle
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(bus.halted || bus.err) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'b0, n < 300}, 32'd1);
    endtask

    initial begin
        cmp = 0; errs = 0;
        rst = 1'b1; bus.start = 1'b0;
        pl_we = 1'b0; pl_a = '0; pl_d = '0;
        clr_imem();
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_komut", bus.komut, 32'h0);
        chk("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", {27'b0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_halted", {31'b0, bus.halted}, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        chk("rst_retired", {16'b0, bus.retired}, 32'd0);
        rst = 1'b0;

        // add x3 = x1 + x2, write lands in cycle 4
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        imem[0] = r_ins(4'b0000, 5'd3, 5'd1, 5'd2);
        expect_wr(5'd3, 32'd12);
        pulse_start();
        chk("t1_busy", {31'b0, bus.busy}, 32'd1);
        chk("t1_c1_wr", {31'b0, bus.wr_en}, 32'd0);
        @(negedge clk); chk("t1_c2_wr", {31'b0, bus.wr_en}, 32'd0);
        @(negedge clk); chk("t1_c3_wr", {31'b0, bus.wr_en}, 32'd0);
        @(negedge clk); chk("t1_c4_wr", {31'b0, bus.wr_en}, 32'd1);
        wait_done();
        chk("t1_halted", {31'b0, bus.halted}, 32'd1);
        chk("t1_pc", bus.pc, 32'd4);
        chk("t1_retired", {16'b0, bus.retired}, 32'd1);
        chk("t1_busy_end", {31'b0, bus.busy}, 32'd0);

        // xori, sub wrap, addi with imm bit 10 set (must not become sub)
        preload(5'd1, 32'h0000_0F0F);
        preload(5'd8, 32'd0);
        preload(5'd9, 32'd1);
        clr_imem();
        imem[0] = i_ins(3'b100, 5'd4, 5'd1, 12'h0FF);
        imem[1] = r_ins(4'b1000, 5'd5, 5'd8, 5'd9);
        imem[2] = i_ins(3'b000, 5'd7, 5'd1, 12'h400);
        expect_wr(5'd4, 32'h0000_0FF0);
        expect_wr(5'd5, 32'hFFFF_FFFF);
        expect_wr(5'd7, 32'h0000_130F);
        pulse_start();
        wait_done();
        chk("t2_pc", bus.pc, 32'd12);
        chk("t2_retired", {16'b0, bus.retired}, 32'd4);

        // shifts (amount masked to 5 bits), or, andi, undefined aluop
        preload(5'd10, 32'h8000_00F0);
        preload(5'd11, 32'h0000_0024);
        clr_imem();
        imem[0] = r_ins(4'b0001, 5'd12, 5'd10, 5'd11);
        imem[1] = r_ins(4'b0101, 5'd13, 5'd10, 5'd11);
        imem[2] = r_ins(4'b1101, 5'd14, 5'd10, 5'd11);
        imem[3] = r_ins(4'b0110, 5'd15, 5'd10, 5'd11);
        imem[4] = i_ins(3'b111, 5'd16, 5'd10, 12'h0F0);
        imem[5] = r_ins(4'b0010, 5'd17, 5'd10, 5'd11);
        expect_wr(5'd12, 32'h0000_0F00);
        expect_wr(5'd13, 32'h0800_000F);
        expect_wr(5'd14, 32'hF800_000F);
        expect_wr(5'd15, 32'h8000_00F4);
        expect_wr(5'd16, 32'h0000_00F0);
        expect_wr(5'd17, 32'h0000_0000);
        pulse_start();
        wait_done();
        chk("t2b_pc", bus.pc, 32'd24);
        chk("t2b_retired", {16'b0, bus.retired}, 32'd10);

        // branches; skipped slots would issue unexpected writes
        preload(5'd21, 32'hFFFF_FFFF);
        clr_imem();
        imem[0] = b_ins(3'b000, 5'd1, 5'd1, 12'd8);
        imem[1] = r_ins(4'b0000, 5'd20, 5'd1, 5'd2);
        imem[2] = b_ins(3'b001, 5'd1, 5'd1, 12'd8);
        imem[3] = b_ins(3'b100, 5'd21, 5'd2, 12'd8);
        imem[4] = r_ins(4'b0000, 5'd20, 5'd1, 5'd2);
        imem[5] = b_ins(3'b101, 5'd21, 5'd2, 12'd8);
        pulse_start();
        repeat (4) @(negedge clk);
        chk("t3_beq_pc", bus.pc, 32'd8);
        repeat (4) @(negedge clk);
        chk("t3_bne_pc", bus.pc, 32'd12);
        wait_done();
        chk("t3_pc", bus.pc, 32'd24);
        chk("t3_retired", {16'b0, bus.retired}, 32'd14);

        // rd=0 write suppressed, U-type
        clr_imem();
        imem[0] = r_ins(4'b0000, 5'd0, 5'd1, 5'd2);
        imem[1] = u_ins(5'd6, 20'hABCDE);
        expect_wr(5'd6, 32'hABCD_E000);
        pulse_start();
        wait_done();
        chk("t5_pc", bus.pc, 32'd8);
        chk("t5_retired", {16'b0, bus.retired}, 32'd16);

        // illegal opcode at pc=8 is terminal
        clr_imem();
        imem[0] = i_ins(3'b000, 5'd22, 5'd1, 12'h001);
        imem[1] = r_ins(4'b0000, 5'd22, 5'd1, 5'd2);
        imem[2] = 32'h0000_007F;
        expect_wr(5'd22, 32'h0000_0F10);
        expect_wr(5'd22, 32'h0000_0F16);
        pulse_start();
        wait_done();
        chk("t4_err", {31'b0, bus.err}, 32'd1);
        chk("t4_busy", {31'b0, bus.busy}, 32'd0);
        chk("t4_pc", bus.pc, 32'd8);
        pulse_start();
        repeat (10) @(negedge clk);
        chk("t4_err_hold", {31'b0, bus.err}, 32'd1);
        chk("t4_busy_hold", {31'b0, bus.busy}, 32'd0);
        chk("t4_halted_hold", {31'b0, bus.halted}, 32'd0);
        chk("t4_pc_hold", bus.pc, 32'd8);
        chk("t4_retired_hold", {16'b0, bus.retired}, 32'd18);

        // async reset during EXEC aborts the pending write
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        preload(5'd1, 32'd5);
        clr_imem();
        imem[0] = r_ins(4'b0000, 5'd23, 5'd1, 5'd2);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_pc", bus.pc, 32'h0);
        chk("t6_komut", bus.komut, 32'h0);
        chk("t6_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("t6_wr_addr", {27'b0, bus.wr_addr}, 32'd0);
        chk("t6_wr_data", bus.wr_data, 32'h0);
        chk("t6_busy", {31'b0, bus.busy}, 32'd0);
        chk("t6_err", {31'b0, bus.err}, 32'd0);
        chk("t6_retired", {16'b0, bus.retired}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_idle_busy", {31'b0, bus.busy}, 32'd0);
        expect_wr(5'd23, 32'd12);
        pulse_start();
        wait_done();
        chk("t6_halted", {31'b0, bus.halted}, 32'd1);
        chk("t6_pc_end", bus.pc, 32'd4);
        chk("t6_retired_end", {16'b0, bus.retired}, 32'd1);

        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
